// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one external combinational 8x8 multiplier.
// Operands are registered, a fixed settle interval elapses, then the tagged product is returned.
module mult_share_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned WAIT_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_p,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      mul_a_q, mul_a_d;
  logic [7:0]      mul_b_q, mul_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_p_q, rsp_p_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic [NREQ-1:0] gnt_onehot;
  logic            xfer;

  // Search starts one past the last served requester; IDW-bit addition wraps modulo NREQ.
  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    gnt_onehot = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_q + IDW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && !rst) begin
      req_ready = gnt_onehot;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          mul_a_d  = req_a[8*gnt_idx +: 8];
          mul_b_d  = req_b[8*gnt_idx +: 8];
          rsp_id_d = gnt_idx;
          last_d   = gnt_idx;
          cnt_d    = 4'(WAIT_CYC);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        // No bypass to a new grant: the IDLE cycle after acceptance is intentional.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one combinational 8x8 multiplier (e.g. `CSA_Mult_8bits`, exact or approximate) among `NREQ` requesters. Each request is accepted through a valid/ready handshake. The block then drives the operands, waits a fixed settle interval sized to the multiplier's post-layout delay, and returns the product tagged with the requester index. It sits between requesting datapath blocks and the multiplier instance, which is outside this block and connected through the `mul_*` ports.

## Interface
- `NREQ`, 4: number of requesters; power of two, 2..8.
- `IDW`, 2: requester-id width, equal to log2(`NREQ`).
- `WAIT_CYC`, 3: clock edges from operand register update to product sampling; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NREQ`: per-requester request strobe.
- `req_a` in `NREQ*8`: operand A; requester i occupies bits [8i+7:8i].
- `req_b` in `NREQ*8`: operand B, packed the same way.
- `req_ready` out `NREQ`: one-hot grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
- `mul_a` out 8: registered operand A to the multiplier.
- `mul_b` out 8: registered operand B to the multiplier.
- `mul_p` in 16: multiplier product; treated as unregistered and slow.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `IDW`: index of the requester that is served.
- `rsp_p` out 16: registered product.
- `busy` out 1: high in SETTLE and RESP.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - `req_ready` is a combinational one-hot function of `req_valid` and the round-robin pointer `last`.
  - The grant goes to the first i with `req_valid[i]`, searching from `last+1` modulo `NREQ`.
  - With no valid request, `req_ready` is 0.
  - On transfer: `mul_a`/`mul_b` take that requester's operands, `rsp_id` takes i, `last` takes i, counter takes `WAIT_CYC`, next state is SETTLE.
- SETTLE:
  - `req_ready` is 0.
  - The counter decrements each edge.
  - At the edge where the counter equals 1: `rsp_p` takes `mul_p`, `rsp_valid` goes to 1, next state is RESP.
- RESP:
  - `req_ready` is 0.
  - `rsp_valid`, `rsp_p` and `rsp_id` hold steady until `rsp_valid` and `rsp_ready` are both high at an edge.
  - At that edge: `rsp_valid` goes to 0 and the next state is IDLE.
  - There is no bypass from RESP straight to a new grant; exactly one bubble cycle follows each response.
- `mul_a`/`mul_b` change only on a transfer edge and hold between transactions. This avoids spurious toggling, which matters for power measurement.
- The product is passed through unmodified; the block does no arithmetic on it.
- Requesters that are not granted keep their request pending. A requester that drops `req_valid` before being granted is never served.

## Timing
- Reset values (at the first edge with `rst`=1):
  - State IDLE.
  - `last` = `NREQ-1`, so requester 0 has priority first.
  - `mul_a` = `mul_b` = 0.
  - `rsp_valid` = 0, `rsp_p` = 0, `rsp_id` = 0, `busy` = 0.
  - `req_ready` = 0 while `rst` is high.
- `rst` overrides every state, including mid-SETTLE and mid-RESP. The in-flight transaction is discarded with no response.
- Latency, with the transfer at edge E:
  - `mul_a`/`mul_b` are valid after E.
  - `mul_p` is sampled at E+`WAIT_CYC`.
  - `rsp_valid` is high after E+`WAIT_CYC`.
- Throughput: with `rsp_ready` held high, one transaction per `WAIT_CYC`+2 cycles.
- If `req_valid` and `rsp_ready` are both high in RESP, only the response completes; the grant is evaluated in the following IDLE cycle.
- Wrap-around: when `last` = `NREQ-1`, the search starts at 0.
- With `WAIT_CYC`=1, `mul_p` is sampled one cycle after the operand update.

## Test plan
- **Single request:** after reset, requester 2 presents A=200, B=3 with `WAIT_CYC`=3.
  - `req_ready` = 4'b0100 in the same cycle.
  - `mul_a`=200 and `mul_b`=3 after E.
  - `rsp_valid` high after E+3 with `rsp_id`=2 and `rsp_p`=600, using an exact multiplier model.
- **Round-robin:** all four requesters hold valid with A=i+1, B=10, and `rsp_ready`=1.
  - Grant order 0,1,2,3,0.
  - Products 10, 20, 30, 40, 10.
  - One grant every 5 cycles.
- **Back-pressure:** `rsp_ready`=0 for 6 cycles after `rsp_valid` rises.
  - `rsp_p`, `rsp_id` and `rsp_valid` stay stable.
  - `req_ready` stays 0 despite pending requests.
  - The next grant comes one cycle after acceptance.
- **Reset mid-SETTLE:** assert `rst` one cycle after the transfer.
  - The next edge gives all reset values.
  - No `rsp_valid` pulse.
  - The next grant goes to requester 0.
- **Minimum settle:** set `WAIT_CYC`=1 and drive A=255, B=255.
  - `rsp_p`=65025 with an exact model.
  - `rsp_valid` high two cycles after `req_valid` is asserted.
- **Sweep against the approximate multiplier:** 10000 random operand pairs, with the responses logged.
  - `rsp_p` always equals the multiplier's own output for the same operands.
  - `mul_a`/`mul_b` never change outside transfer edges.
